// File: rtl/ddr5_rcd_ca_pkg.sv
// Shared CA bus definitions for the RCD command sources, arbiter and protocol checkers.
package ddr5_rcd_ca_pkg;

  localparam int CA_CMD_W  = 7;
  localparam int CA_ADDR_W = 17;
  localparam int CA_CS_W   = 2;
  localparam int NUM_CS    = 4;

  typedef struct packed {
    logic [CA_CMD_W-1:0]  cmd;
    logic [CA_ADDR_W-1:0] addr;
    logic [CA_CS_W-1:0]   cs;
  } ca_cmd_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ALERT   = 2'd1,
    ST_RECOVER = 2'd2
  } ca_arb_state_t;

endpackage

// File: rtl/ddr5_rcd_rr_arbiter.sv
// Combinational grant selection: fixed-priority requester first, then round-robin
// among the rest starting just after rr_ptr_i. Output is one-hot or zero.
module ddr5_rcd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PRI_REQ = 0
) (
  input  logic [NUM_REQ-1:0]         elig_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] PRI_IDX = IDX_W'(PRI_REQ);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    if (elig_i[PRI_REQ]) begin
      gnt_o[PRI_REQ] = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
        if (!found && idx != PRI_IDX && elig_i[idx]) begin
          gnt_o[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr5_rcd_ca_arbiter.sv
// RCD CA bus arbiter: shares the CA pins between NUM_REQ sources, enforces per-chip-select
// command spacing and runs the parity-error alert/recover sequence.
module ddr5_rcd_ca_arbiter
  import ddr5_rcd_ca_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PRI_REQ      = 0,
  parameter int GAP_CYCLES   = 2,
  parameter int ALERT_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*CA_CMD_W-1:0]   req_cmd,
  input  logic [NUM_REQ*CA_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*CA_CS_W-1:0]    req_cs,
  input  logic                          parity_err,
  output logic                          ca_valid,
  output logic [CA_CMD_W-1:0]           ca_cmd,
  output logic [CA_ADDR_W-1:0]          ca_addr,
  output logic [CA_CS_W-1:0]            ca_cs,
  output logic                          alert_n,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int ACNT_W = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  PRI_IDX   = IDX_W'(PRI_REQ);
  localparam logic [GAP_W-1:0]  GAP_RLD   = GAP_W'(GAP_CYCLES);
  localparam logic [ACNT_W-1:0] ALERT_RLD = ACNT_W'(ALERT_CYCLES - 1);

  ca_arb_state_t                   state_q, state_d;
  logic [ACNT_W-1:0]               alert_cnt_q, alert_cnt_d;
  logic [NUM_CS-1:0][GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
  ca_cmd_t                         ca_q, ca_d;
  logic                            ca_valid_q;
  logic [IDX_W-1:0]                grant_id_q, grant_id_d;
  logic                            alert_n_q;

  ca_cmd_t [NUM_REQ-1:0]           req_s;
  logic [NUM_REQ-1:0]              elig, gnt;
  ca_cmd_t                         win;
  logic [IDX_W-1:0]                win_idx;
  logic                            xfer, clr_gap;

  // Requesters waiting on a busy chip select drop out of the mask so they never block others.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req_s[i] = {req_cmd[i*CA_CMD_W +: CA_CMD_W],
                       req_addr[i*CA_ADDR_W +: CA_ADDR_W],
                       req_cs[i*CA_CS_W +: CA_CS_W]};
    assign elig[i]  = req_valid[i] & (gap_cnt_q[req_s[i].cs] == '0);
  end

  ddr5_rcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PRI_REQ (PRI_REQ)
  ) u_rr_arb (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (gnt)
  );

  assign req_ready = (!rst && state_q == ST_RUN && !parity_err) ? gnt : '0;
  assign xfer      = |req_ready;

  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        win     = req_s[k];
        win_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    alert_cnt_d = alert_cnt_q;
    clr_gap     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (parity_err) begin
          state_d     = ST_ALERT;
          alert_cnt_d = ALERT_RLD;
        end
      end
      ST_ALERT: begin
        if (parity_err) begin
          alert_cnt_d = ALERT_RLD;
        end else if (alert_cnt_q == '0) begin
          state_d = ST_RECOVER;
        end else begin
          alert_cnt_d = alert_cnt_q - ACNT_W'(1);
        end
      end
      ST_RECOVER: begin
        clr_gap = 1'b1;
        if (parity_err) begin
          state_d     = ST_ALERT;
          alert_cnt_d = ALERT_RLD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // A fresh grant reloads its own counter; every other busy counter drains by one.
  always_comb begin
    for (int k = 0; k < NUM_CS; k++) begin
      gap_cnt_d[k] = gap_cnt_q[k];
      if (clr_gap) begin
        gap_cnt_d[k] = '0;
      end else if (xfer && win.cs == CA_CS_W'(k)) begin
        gap_cnt_d[k] = GAP_RLD;
      end else if (gap_cnt_q[k] != '0) begin
        gap_cnt_d[k] = gap_cnt_q[k] - GAP_W'(1);
      end
    end
  end

  assign rr_ptr_d   = (xfer && win_idx != PRI_IDX) ? win_idx : rr_ptr_q;
  assign ca_d       = xfer ? win : '0;
  assign grant_id_d = xfer ? win_idx : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      alert_cnt_q <= '0;
      gap_cnt_q   <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      ca_q        <= '0;
      ca_valid_q  <= 1'b0;
      grant_id_q  <= '0;
      alert_n_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      alert_cnt_q <= alert_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      ca_q        <= ca_d;
      ca_valid_q  <= xfer;
      grant_id_q  <= grant_id_d;
      alert_n_q   <= (state_d != ST_ALERT);
    end
  end

  assign ca_valid = ca_valid_q;
  assign ca_cmd   = ca_q.cmd;
  assign ca_addr  = ca_q.addr;
  assign ca_cs    = ca_q.cs;
  assign alert_n  = alert_n_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_ddr5_rcd_ca_arbiter.sv
// Directed bench for the CA arbiter: reset, round-robin, cs spacing, parity alert,
// alert extension and reset during an alert pulse.
module tb_ddr5_rcd_ca_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [27:0] req_cmd;
  logic [67:0] req_addr;
  logic [7:0]  req_cs;
  logic        parity_err;
  logic        ca_valid;
  logic [6:0]  ca_cmd;
  logic [16:0] ca_addr;
  logic [1:0]  ca_cs;
  logic        alert_n;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  ddr5_rcd_ca_arbiter #(
    .NUM_REQ(4), .PRI_REQ(0), .GAP_CYCLES(2), .ALERT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_cs(req_cs),
    .parity_err(parity_err), .ca_valid(ca_valid), .ca_cmd(ca_cmd),
    .ca_addr(ca_addr), .ca_cs(ca_cs), .alert_n(alert_n), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [6:0] c, input logic [1:0] cs);
    req_valid[i]        = v;
    req_cmd[i*7 +: 7]   = c;
    req_addr[i*17 +: 17] = 17'h100 + 17'(c);
    req_cs[i*2 +: 2]    = cs;
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; parity_err = 1'b0;
    req_valid = '0; req_cmd = '0; req_addr = '0; req_cs = '0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 7'(8'h10 + i), 2'(i));

    for (int n = 0; n < 3; n++) begin
      tick(); #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_ca_valid", 32'(ca_valid), 32'h0);
      chk("rst_alert_n", 32'(alert_n), 32'h1);
      chk("rst_grant_id", 32'(grant_id), 32'h0);
    end
    rst = 1'b0; #1;
    chk("c0_ready_pri", 32'(req_ready), 32'h1);

    tick(); set_req(0, 1'b0, 7'h10, 2'd0); #1;
    chk("c1_ca_valid", 32'(ca_valid), 32'h1);
    chk("c1_grant_id", 32'(grant_id), 32'h0);
    chk("c1_ca_cmd", 32'(ca_cmd), 32'h10);
    chk("c1_ca_addr", 32'(ca_addr), 32'h110);
    chk("c1_ready", 32'(req_ready), 32'h2);

    tick(); #1;
    chk("c2_grant_id", 32'(grant_id), 32'h1);
    chk("c2_ca_cs", 32'(ca_cs), 32'h1);
    chk("c2_ready", 32'(req_ready), 32'h4);
    tick(); #1;
    chk("c3_grant_id", 32'(grant_id), 32'h2);
    chk("c3_ready", 32'(req_ready), 32'h8);
    tick(); #1;
    chk("c4_grant_id", 32'(grant_id), 32'h3);
    chk("c4_ready", 32'(req_ready), 32'h2);
    tick(); set_req(1, 1'b1, 7'h21, 2'd0); #1;
    chk("c5_grant_id", 32'(grant_id), 32'h1);
    chk("c5_ready", 32'(req_ready), 32'h4);
    tick(); set_req(2, 1'b1, 7'h22, 2'd0); #1;
    chk("c6_ca_valid", 32'(ca_valid), 32'h1);
    chk("c6_grant_id", 32'(grant_id), 32'h2);
    chk("c6_ready", 32'(req_ready), 32'h8);
    tick(); set_req(3, 1'b0, 7'h13, 2'd3); #1;
    chk("c7_grant_id", 32'(grant_id), 32'h3);
    chk("c7_ready", 32'(req_ready), 32'h2);

    // Both remaining requesters target cs0: one grant every third cycle.
    tick(); #1;
    chk("c8_ca_valid", 32'(ca_valid), 32'h1);
    chk("c8_grant_id", 32'(grant_id), 32'h1);
    chk("c8_ca_cmd", 32'(ca_cmd), 32'h21);
    chk("c8_ca_cs", 32'(ca_cs), 32'h0);
    chk("c8_ready_gap", 32'(req_ready), 32'h0);
    tick(); #1;
    chk("c9_ca_valid", 32'(ca_valid), 32'h0);
    chk("c9_ca_cmd_zero", 32'(ca_cmd), 32'h0);
    chk("c9_ready_gap", 32'(req_ready), 32'h0);
    tick(); #1;
    chk("c10_ready", 32'(req_ready), 32'h4);
    tick(); #1;
    chk("c11_ca_valid", 32'(ca_valid), 32'h1);
    chk("c11_grant_id", 32'(grant_id), 32'h2);
    chk("c11_ready_gap", 32'(req_ready), 32'h0);
    tick(); #1;
    chk("c12_ready_gap", 32'(req_ready), 32'h0);
    tick(); #1;
    chk("c13_ready", 32'(req_ready), 32'h2);

    // Single parity error at t with req2 pending.
    tick(); set_req(1, 1'b0, 7'h21, 2'd0); parity_err = 1'b1; #1;
    chk("par_t_ca_valid", 32'(ca_valid), 32'h1);
    chk("par_t_ready", 32'(req_ready), 32'h0);
    chk("par_t_alert_n", 32'(alert_n), 32'h1);
    for (int n = 1; n <= 8; n++) begin
      tick(); parity_err = 1'b0; #1;
      chk("par_alert_n", 32'(alert_n), 32'h0);
      chk("par_ready", 32'(req_ready), 32'h0);
      chk("par_ca_valid", 32'(ca_valid), 32'h0);
    end
    tick(); #1;
    chk("par_rec_alert_n", 32'(alert_n), 32'h1);
    chk("par_rec_ready", 32'(req_ready), 32'h0);
    tick(); #1;
    chk("par_resume_ready", 32'(req_ready), 32'h4);

    // Parity error, then a second one four cycles later extends the pulse.
    tick(); set_req(2, 1'b0, 7'h22, 2'd0); set_req(1, 1'b1, 7'h31, 2'd1); parity_err = 1'b1; #1;
    chk("par_resume_ca_valid", 32'(ca_valid), 32'h1);
    chk("par_resume_grant_id", 32'(grant_id), 32'h2);
    chk("ext_t_ready", 32'(req_ready), 32'h0);
    for (int n = 1; n <= 12; n++) begin
      tick(); parity_err = (n == 4); #1;
      chk("ext_alert_n", 32'(alert_n), 32'h0);
      chk("ext_ready", 32'(req_ready), 32'h0);
    end
    tick(); parity_err = 1'b0; #1;
    chk("ext_rec_alert_n", 32'(alert_n), 32'h1);
    chk("ext_rec_ready", 32'(req_ready), 32'h0);
    tick(); #1;
    chk("ext_resume_ready", 32'(req_ready), 32'h2);

    // Reset during an alert pulse; rr_ptr must restart so req1 beats req3.
    tick(); set_req(3, 1'b1, 7'h33, 2'd3); parity_err = 1'b1; #1;
    chk("ext_ca_valid", 32'(ca_valid), 32'h1);
    chk("ext_ca_cmd", 32'(ca_cmd), 32'h31);
    chk("mid_t_ready", 32'(req_ready), 32'h0);
    tick(); parity_err = 1'b0; #1;
    chk("mid_alert_n1", 32'(alert_n), 32'h0);
    tick(); #1;
    chk("mid_alert_n2", 32'(alert_n), 32'h0);
    tick(); rst = 1'b1; #1;
    chk("mid_alert_n3", 32'(alert_n), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick(); rst = 1'b0; #1;
    chk("mid_post_alert_n", 32'(alert_n), 32'h1);
    chk("mid_post_ca_valid", 32'(ca_valid), 32'h0);
    chk("mid_post_ready_rr", 32'(req_ready), 32'h2);
    tick(); #1;
    chk("mid_post_ca_valid2", 32'(ca_valid), 32'h1);
    chk("mid_post_grant_id", 32'(grant_id), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
